// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, grant
// identifiers and the request-mask helper used during the response cycle.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        RESP_I  = 3'd2,
        ISSUE_D = 3'd3,
        RESP_D  = 3'd4
    } state_e;

    // The value doubles as the bit position of each port in request/mask vectors.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam logic [1:0]  MASK_I = 2'b01;
    localparam logic [1:0]  MASK_D = 2'b10;

    // The master being acked this cycle may not win the next grant.
    function automatic logic [1:0] resp_mask(input state_e s);
        logic [1:0] m;
        m = 2'b00;
        if (s == RESP_I) begin
            m = MASK_I;
        end else if (s == RESP_D) begin
            m = MASK_D;
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way grant selection: masked requests, then fixed data priority or
// round-robin (last-granted loses) on a tie.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic       req_i,
    input  logic       req_d,
    input  logic [1:0] mask,
    input  gnt_e       last_gnt,
    output logic       gnt_valid,
    output gnt_e       gnt
);

    logic [1:0] req_raw;
    logic [1:0] req_m;

    assign req_raw = {req_d, req_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mask
            assign req_m[gi] = req_raw[gi] & ~mask[gi];
        end
    endgenerate

    always_comb begin
        gnt_valid = |req_m;
        gnt       = GNT_I;
        if (req_m == 2'b11) begin
            if (D_PRIORITY) begin
                gnt = GNT_D;
            end else begin
                gnt = (last_gnt == GNT_D) ? GNT_I : GNT_D;
            end
        end else if (req_m[1]) begin
            gnt = GNT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory bus;
// one outstanding transfer, back-to-back grants at one transfer per two cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_adr_i,
    input  logic          i_stb_i,
    output logic [DW-1:0] i_dat_o,
    output logic          i_ack_o,
    input  logic [DW-1:0] d_dat_i,
    input  logic [AW-1:0] d_adr_i,
    input  logic          d_we_i,
    input  logic          d_stb_i,
    output logic [DW-1:0] d_dat_o,
    output logic          d_ack_o,
    output logic [DW-1:0] m_dat_o,
    output logic [AW-1:0] m_adr_o,
    output logic          m_we_o,
    output logic          m_stb_o,
    input  logic [DW-1:0] m_dat_i,
    input  logic          m_ack_i
);

    state_e        state_q, state_d;
    gnt_e          last_q, last_d;
    logic [AW-1:0] m_adr_q, m_adr_d;
    logic [DW-1:0] m_dat_q, m_dat_d;
    logic          m_we_q, m_we_d;
    logic          m_stb_q, m_stb_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] i_hold_q, i_hold_d;
    logic [DW-1:0] d_hold_q, d_hold_d;

    logic          pick_valid;
    gnt_e          pick_gnt;

    mem_arb_pick #(
        .D_PRIORITY (D_PRIORITY)
    ) u_pick (
        .req_i     (i_stb_i),
        .req_d     (d_stb_i),
        .mask      (resp_mask(state_q)),
        .last_gnt  (last_q),
        .gnt_valid (pick_valid),
        .gnt       (pick_gnt)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        m_adr_d  = m_adr_q;
        m_dat_d  = m_dat_q;
        m_we_d   = m_we_q;
        m_stb_d  = 1'b0;
        i_ack_d  = 1'b0;
        d_ack_d  = 1'b0;
        i_hold_d = i_hold_q;
        d_hold_d = d_hold_q;

        unique case (state_q)
            ISSUE_I: begin
                if (m_ack_i) begin
                    state_d = RESP_I;
                    i_ack_d = 1'b1;
                end else begin
                    m_stb_d = 1'b1;
                end
            end
            ISSUE_D: begin
                if (m_ack_i) begin
                    state_d = RESP_D;
                    d_ack_d = 1'b1;
                end else begin
                    m_stb_d = 1'b1;
                end
            end
            default: begin
                // IDLE and both RESP states: capture read data, then arbitrate.
                if (state_q == RESP_I) begin
                    i_hold_d = m_dat_i;
                end
                if (state_q == RESP_D && !m_we_q) begin
                    d_hold_d = m_dat_i;
                end
                state_d = IDLE;
                if (pick_valid) begin
                    last_d  = pick_gnt;
                    m_stb_d = 1'b1;
                    if (pick_gnt == GNT_D) begin
                        state_d = ISSUE_D;
                        m_adr_d = d_adr_i;
                        m_dat_d = d_dat_i;
                        m_we_d  = d_we_i;
                    end else begin
                        state_d = ISSUE_I;
                        m_adr_d = i_adr_i;
                        m_dat_d = '0;
                        m_we_d  = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= GNT_I;
            m_adr_q  <= '0;
            m_dat_q  <= '0;
            m_we_q   <= 1'b0;
            m_stb_q  <= 1'b0;
            i_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            i_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            m_adr_q  <= m_adr_d;
            m_dat_q  <= m_dat_d;
            m_we_q   <= m_we_d;
            m_stb_q  <= m_stb_d;
            i_ack_q  <= i_ack_d;
            d_ack_q  <= d_ack_d;
            i_hold_q <= i_hold_d;
            d_hold_q <= d_hold_d;
        end
    end

    assign m_adr_o = m_adr_q;
    assign m_dat_o = m_dat_q;
    assign m_we_o  = m_we_q;
    assign m_stb_o = m_stb_q;
    assign i_ack_o = i_ack_q;
    assign d_ack_o = d_ack_q;

    // Memory data is only valid in the response cycle, so pass it straight through there.
    assign i_dat_o = (state_q == RESP_I) ? m_dat_i : i_hold_q;
    assign d_dat_o = (state_q == RESP_D && !m_we_q) ? m_dat_i : d_hold_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses data priority, instance 1 round-robin;
// each has its own wait-state-capable memory model and a transaction-level reference.
module tb_mem_arbiter;

    logic             clk = 1'b0;
    logic [1:0]       rst_n;
    logic [1:0][31:0] i_adr, i_dat, d_wdat, d_adr, d_dat, m_wdat, m_adr, m_rdat;
    logic [1:0]       i_stb, i_ack, d_we, d_stb, d_ack, m_we, m_stb, m_ack;

    always #5 clk = ~clk;

    mem_arbiter #(.D_PRIORITY(1'b1)) u_dut_p (
        .clk(clk), .rst_n(rst_n[0]),
        .i_adr_i(i_adr[0]), .i_stb_i(i_stb[0]), .i_dat_o(i_dat[0]), .i_ack_o(i_ack[0]),
        .d_dat_i(d_wdat[0]), .d_adr_i(d_adr[0]), .d_we_i(d_we[0]), .d_stb_i(d_stb[0]),
        .d_dat_o(d_dat[0]), .d_ack_o(d_ack[0]),
        .m_dat_o(m_wdat[0]), .m_adr_o(m_adr[0]), .m_we_o(m_we[0]), .m_stb_o(m_stb[0]),
        .m_dat_i(m_rdat[0]), .m_ack_i(m_ack[0])
    );

    mem_arbiter #(.D_PRIORITY(1'b0)) u_dut_rr (
        .clk(clk), .rst_n(rst_n[1]),
        .i_adr_i(i_adr[1]), .i_stb_i(i_stb[1]), .i_dat_o(i_dat[1]), .i_ack_o(i_ack[1]),
        .d_dat_i(d_wdat[1]), .d_adr_i(d_adr[1]), .d_we_i(d_we[1]), .d_stb_i(d_stb[1]),
        .d_dat_o(d_dat[1]), .d_ack_o(d_ack[1]),
        .m_dat_o(m_wdat[1]), .m_adr_o(m_adr[1]), .m_we_o(m_we[1]), .m_stb_o(m_stb[1]),
        .m_dat_i(m_rdat[1]), .m_ack_i(m_ack[1])
    );

    // Memory models: stall_cfg zero-ack cycles per strobe, read data registered, junk otherwise.
    logic [31:0] mem [2][256];
    int          stall_cfg [2];
    int          stall_cnt [2];
    logic        mem_clr;
    logic [1:0]  bd_en;
    logic [31:0] bd_adr, bd_dat;

    assign m_ack[0] = m_stb[0] && (stall_cnt[0] == 0);
    assign m_ack[1] = m_stb[1] && (stall_cnt[1] == 0);

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_clr) begin
                for (int a = 0; a < 256; a++) mem[k][a] <= '0;
            end else if (bd_en[k]) begin
                mem[k][bd_adr[9:2]] <= bd_dat;
            end
            m_rdat[k] <= $urandom();
            if (!m_stb[k]) begin
                stall_cnt[k] <= stall_cfg[k];
            end else if (stall_cnt[k] != 0) begin
                stall_cnt[k] <= stall_cnt[k] - 1;
            end else begin
                stall_cnt[k] <= stall_cfg[k];
                if (m_we[k]) mem[k][m_adr[k][9:2]] <= m_wdat[k];
                else         m_rdat[k] <= mem[k][m_adr[k][9:2]];
            end
        end
    end

    int          checks = 0;
    int          failures = 0;
    logic [31:0] ref_mem [2][256];
    bit          ref_last_d [2];
    logic [31:0] ref_ihold [2];
    logic [31:0] ref_dhold [2];

    logic [63:0] ia_bits, da_bits, ms_bits, mwe_bits;
    logic [31:0] idat_log [64];
    logic [31:0] ddat_log [64];
    logic [31:0] madr_log [64];
    logic [31:0] mdat_log [64];

    // Observe n cycles after the request cycle; masters drop stb on their ack unless hold.
    task automatic run(input int k, input int n, input int drop_at, input bit hold);
        ia_bits = '0; da_bits = '0; ms_bits = '0; mwe_bits = '0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            ia_bits[c]  = i_ack[k];
            da_bits[c]  = d_ack[k];
            ms_bits[c]  = m_stb[k];
            mwe_bits[c] = m_we[k];
            idat_log[c] = i_dat[k];
            ddat_log[c] = d_dat[k];
            madr_log[c] = m_adr[k];
            mdat_log[c] = m_wdat[k];
            if (!hold) begin
                if (i_ack[k]) i_stb[k] = 1'b0;
                if (d_ack[k]) d_stb[k] = 1'b0;
            end
            if (c == drop_at) begin
                i_stb[k] = 1'b0;
                d_stb[k] = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input bit clr);
        @(negedge clk);
        rst_n = 2'b00; mem_clr = clr;
        i_stb = '0; d_stb = '0; d_we = '0;
        i_adr = '0; d_adr = '0; d_wdat = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 2'b11; mem_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ref_last_d[k] = 1'b0;
            ref_ihold[k]  = '0;
            ref_dhold[k]  = '0;
            if (clr) for (int a = 0; a < 256; a++) ref_mem[k][a] = '0;
        end
    endtask

    task automatic backdoor(input int k, input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        bd_en[k] = 1'b1; bd_adr = a; bd_dat = v;
        @(negedge clk);
        bd_en = '0;
        ref_mem[k][a[9:2]] = v;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({m_stb[k], m_we[k], i_ack[k], d_ack[k]} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_ctrl inst%0d: stb/we/iack/dack=%b required 0000", k,
                         {m_stb[k], m_we[k], i_ack[k], d_ack[k]});
            end
            checks++;
            if (m_adr[k] !== 32'h0 || m_wdat[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset_bus inst%0d: adr=%h dat=%h required 0", k, m_adr[k], m_wdat[k]);
            end
            checks++;
            if (i_dat[k] !== 32'h0 || d_dat[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset_dat inst%0d: i_dat=%h d_dat=%h required 0", k, i_dat[k], d_dat[k]);
            end
        end
    endtask

    task automatic test_single_read();
        backdoor(0, 32'h10, 32'h2402_0005);
        @(negedge clk);
        i_adr[0] = 32'h10; i_stb[0] = 1'b1;
        run(0, 5, -1, 1'b0);
        $display("txn single_read adr=00000010 iack_bits=%h dat=%h", ia_bits, idat_log[2]);
        checks++;
        if (ia_bits !== 64'h4 || da_bits !== 64'h0) begin
            failures++;
            $display("FAIL single_read_ack: i=%h d=%h required i=4 d=0", ia_bits, da_bits);
        end
        checks++;
        if (idat_log[2] !== 32'h2402_0005 || idat_log[5] !== 32'h2402_0005) begin
            failures++;
            $display("FAIL single_read_dat: resp=%h later=%h required 24020005", idat_log[2], idat_log[5]);
        end
        checks++;
        if (ms_bits !== 64'h2 || madr_log[1] !== 32'h10 || mwe_bits[1] !== 1'b0 || mdat_log[1] !== 32'h0) begin
            failures++;
            $display("FAIL single_read_bus: stb=%h adr=%h we=%b dat=%h required stb=2 adr=10 we=0 dat=0",
                     ms_bits, madr_log[1], mwe_bits[1], mdat_log[1]);
        end
    endtask

    task automatic test_tie_priority();
        @(negedge clk);
        i_adr[0] = 32'h0;   i_stb[0] = 1'b1;
        d_adr[0] = 32'h100; d_wdat[0] = 32'hDEAD_BEEF; d_we[0] = 1'b1; d_stb[0] = 1'b1;
        run(0, 6, -1, 1'b0);
        $display("txn tie_priority dack_bits=%h iack_bits=%h", da_bits, ia_bits);
        checks++;
        if (da_bits !== 64'h4 || ia_bits !== 64'h10) begin
            failures++;
            $display("FAIL tie_order: d=%h i=%h required d=4 i=10", da_bits, ia_bits);
        end
        checks++;
        if (idat_log[4] !== 32'h0 || ddat_log[2] !== 32'h0) begin
            failures++;
            $display("FAIL tie_dat: i_dat=%h d_dat_on_write=%h required 0 and 0", idat_log[4], ddat_log[2]);
        end
        @(negedge clk);
        d_we[0] = 1'b0; i_adr[0] = 32'h100; i_stb[0] = 1'b1;
        run(0, 4, -1, 1'b0);
        $display("txn readback adr=00000100 dat=%h", idat_log[2]);
        checks++;
        if (ia_bits !== 64'h4 || idat_log[2] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL tie_readback: ack=%h dat=%h required ack=4 dat=deadbeef", ia_bits, idat_log[2]);
        end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        i_adr[1] = 32'h40; d_adr[1] = 32'h80; d_we[1] = 1'b0;
        i_stb[1] = 1'b1;   d_stb[1] = 1'b1;
        run(1, 18, 16, 1'b1);
        $display("txn round_robin dack_bits=%h iack_bits=%h", da_bits, ia_bits);
        checks++;
        if (da_bits !== 64'h4444 || ia_bits !== 64'h11110) begin
            failures++;
            $display("FAIL rr_alternate: d=%h i=%h required d=4444 i=11110", da_bits, ia_bits);
        end
        ref_last_d[1] = 1'b0;
    endtask

    task automatic test_wait_states();
        logic [31:0] v;
        v = $urandom();
        stall_cfg[0] = 3;
        @(negedge clk);
        d_adr[0] = 32'h180; d_wdat[0] = v; d_we[0] = 1'b1; d_stb[0] = 1'b1;
        run(0, 7, -1, 1'b0);
        stall_cfg[0] = 0;
        $display("txn wait_states dat=%h dack_bits=%h", v, da_bits);
        checks++;
        if (da_bits !== 64'h20 || ms_bits !== 64'h1E) begin
            failures++;
            $display("FAIL wait_ack: dack=%h stb=%h required dack=20 stb=1e", da_bits, ms_bits);
        end
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (madr_log[c] !== 32'h180 || mdat_log[c] !== v || mwe_bits[c] !== 1'b1) begin
                failures++;
                $display("FAIL wait_stable c%0d: adr=%h dat=%h we=%b required 180 %h 1",
                         c, madr_log[c], mdat_log[c], mwe_bits[c], v);
            end
        end
    endtask

    task automatic test_reset_mid();
        stall_cfg[0] = 2;
        @(negedge clk);
        i_adr[0] = 32'h20; i_stb[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (m_stb[0] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_issue: m_stb=%b required 1", m_stb[0]);
        end
        rst_n[0] = 1'b0; i_stb[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_stb[0], m_we[0], i_ack[0], d_ack[0]} !== 4'b0 || m_adr[0] !== 32'h0 ||
            m_wdat[0] !== 32'h0 || i_dat[0] !== 32'h0 || d_dat[0] !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_outputs: ctrl=%b adr=%h dat=%h idat=%h ddat=%h required all 0",
                     {m_stb[0], m_we[0], i_ack[0], d_ack[0]}, m_adr[0], m_wdat[0], i_dat[0], d_dat[0]);
        end
        rst_n[0] = 1'b1; stall_cfg[0] = 0;
        ref_last_d[0] = 1'b0; ref_ihold[0] = '0; ref_dhold[0] = '0;
        run(0, 5, -1, 1'b0);
        checks++;
        if (ia_bits !== 64'h0 || ms_bits !== 64'h0) begin
            failures++;
            $display("FAIL rstmid_quiet: iack=%h stb=%h required 0", ia_bits, ms_bits);
        end
        @(negedge clk);
        i_adr[0] = 32'h20; i_stb[0] = 1'b1;
        run(0, 4, -1, 1'b0);
        $display("txn reset_mid restart iack_bits=%h", ia_bits);
        checks++;
        if (ia_bits !== 64'h4) begin
            failures++;
            $display("FAIL rstmid_restart: iack=%h required 4", ia_bits);
        end
    endtask

    task automatic test_stb_drop();
        logic [31:0] v;
        v = $urandom();
        stall_cfg[0] = 2;
        @(negedge clk);
        d_adr[0] = 32'h200; d_wdat[0] = v; d_we[0] = 1'b1; d_stb[0] = 1'b1;
        run(0, 7, 1, 1'b0);
        stall_cfg[0] = 0;
        $display("txn stb_drop dat=%h dack_bits=%h", v, da_bits);
        checks++;
        if (da_bits !== 64'h10) begin
            failures++;
            $display("FAIL drop_ack: dack=%h required 10", da_bits);
        end
        @(negedge clk);
        d_we[0] = 1'b0; i_adr[0] = 32'h200; i_stb[0] = 1'b1;
        run(0, 4, -1, 1'b0);
        checks++;
        if (ia_bits !== 64'h4 || idat_log[2] !== v) begin
            failures++;
            $display("FAIL drop_landed: ack=%h dat=%h required ack=4 dat=%h", ia_bits, idat_log[2], v);
        end
    endtask

    task automatic test_random();
        int          k, s, cyc, n_ord, ci, cd;
        int          order [2];
        logic [1:0]  reqs;
        logic [31:0] ia, da, dv, exp_idat, exp_ddat;
        logic        dwe;
        logic [63:0] exp_ia, exp_da;
        do_reset(1'b1);
        for (int t = 0; t < 24; t++) begin
            k    = int'($urandom_range(0, 1));
            reqs = 2'($urandom_range(1, 3));
            s    = int'($urandom_range(0, 2));
            ia   = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
            da   = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
            dv   = $urandom();
            dwe  = 1'($urandom_range(0, 1));
            stall_cfg[k] = s;
            @(negedge clk);
            i_adr[k] = ia; i_stb[k] = reqs[0];
            d_adr[k] = da; d_wdat[k] = dv; d_we[k] = dwe; d_stb[k] = reqs[1];
            // Reference: order of service, then sequential effect on memory and hold registers.
            if (reqs == 2'b11) begin
                order[0] = (k == 0) ? 1 : (ref_last_d[k] ? 0 : 1);
                order[1] = 1 - order[0];
                n_ord = 2;
            end else begin
                order[0] = reqs[1] ? 1 : 0;
                n_ord = 1;
            end
            exp_ia = '0; exp_da = '0; cyc = 0; ci = 0; cd = 0;
            exp_idat = '0; exp_ddat = '0;
            for (int j = 0; j < n_ord; j++) begin
                cyc += 2 + s;
                if (order[j] == 0) begin
                    exp_ia[cyc] = 1'b1; ci = cyc;
                    exp_idat = ref_mem[k][ia[9:2]];
                    ref_ihold[k] = exp_idat;
                end else begin
                    exp_da[cyc] = 1'b1; cd = cyc;
                    if (dwe) begin
                        ref_mem[k][da[9:2]] = dv;
                    end else begin
                        exp_ddat = ref_mem[k][da[9:2]];
                        ref_dhold[k] = exp_ddat;
                    end
                end
                ref_last_d[k] = (order[j] == 1);
            end
            run(k, 10, -1, 1'b0);
            stall_cfg[k] = 0;
            $display("txn rnd%0d inst=%0d req=%b stall=%0d ia=%h da=%h we=%b iack=%h dack=%h",
                     t, k, reqs, s, ia, da, dwe, ia_bits, da_bits);
            checks++;
            if (ia_bits !== exp_ia || da_bits !== exp_da) begin
                failures++;
                $display("FAIL rnd_acks t%0d: i=%h d=%h required i=%h d=%h", t, ia_bits, da_bits, exp_ia, exp_da);
            end
            checks++;
            if ((ia_bits & da_bits) !== 64'h0) begin
                failures++;
                $display("FAIL rnd_dual_ack t%0d: overlap=%h required 0", t, ia_bits & da_bits);
            end
            if (ci != 0) begin
                checks++;
                if (idat_log[ci] !== exp_idat) begin
                    failures++;
                    $display("FAIL rnd_idat t%0d: got %h required %h", t, idat_log[ci], exp_idat);
                end
            end
            if (cd != 0 && !dwe) begin
                checks++;
                if (ddat_log[cd] !== exp_ddat) begin
                    failures++;
                    $display("FAIL rnd_ddat t%0d: got %h required %h", t, ddat_log[cd], exp_ddat);
                end
            end
            checks++;
            if (idat_log[10] !== ref_ihold[k] || ddat_log[10] !== ref_dhold[k]) begin
                failures++;
                $display("FAIL rnd_hold t%0d: i=%h d=%h required i=%h d=%h",
                         t, idat_log[10], ddat_log[10], ref_ihold[k], ref_dhold[k]);
            end
        end
    endtask

    initial begin
        rst_n = 2'b00; mem_clr = 1'b0; bd_en = '0; bd_adr = '0; bd_dat = '0;
        i_stb = '0; d_stb = '0; d_we = '0; i_adr = '0; d_adr = '0; d_wdat = '0;
        stall_cfg[0] = 0; stall_cfg[1] = 0;
        test_reset();
        test_single_read();
        test_tie_priority();
        test_round_robin();
        test_wait_states();
        test_reset_mid();
        test_stb_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter D_PRIORITY, default 1; 1 = data port always wins a tie, 0 = round-robin on ties (last-granted loses).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL provide port i_adr_i  input  32  instruction-fetch byte address.
REQ-005 SHALL provide port i_stb_i  input  1  instruction-fetch request; read-only port.
REQ-006 SHALL provide port i_dat_o  output  32  instruction read data.
REQ-007 SHALL provide port i_ack_o  output  1  instruction transfer complete.
REQ-008 SHALL provide port d_dat_i  input  32  data-port write data.
REQ-009 SHALL provide port d_adr_i  input  32  data-port byte address.
REQ-010 SHALL provide port d_we_i  input  1  data-port write enable.
REQ-011 SHALL provide port d_stb_i  input  1  data-port request.
REQ-012 SHALL provide port d_dat_o  output  32  data-port read data.
REQ-013 SHALL provide port d_ack_o  output  1  data transfer complete.
REQ-014 SHALL provide ports m_dat_o (output, 32), m_adr_o (output, 32), m_we_o (output, 1) and m_stb_o (output, 1), driving the shared unified memory.
REQ-015 SHALL provide ports m_dat_i (input, 32, memory read data, registered, valid the cycle after the accepted strobe) and m_ack_i (input, 1, memory accept).

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE_I, RESP_I, ISSUE_D, RESP_D.
REQ-017 SHALL, in IDLE, go to ISSUE_D or ISSUE_I per winner; stay in IDLE if neither stb is high.
REQ-018 SHALL, on a tie, grant d when D_PRIORITY=1; otherwise grant the port not granted last (d after reset).
REQ-019 SHALL latch the winner's adr/we/dat on grant, hold them constant through ISSUE, and drive them on m_* with m_stb_o=1 only in ISSUE_*.
REQ-020 SHALL force m_we_o=0 and m_dat_o=0 for instruction grants.
REQ-021 SHALL stay in ISSUE_* while m_ack_i=0 and advance to RESP_* on the edge where m_ack_i=1.
REQ-022 SHALL, in RESP_*, assert exactly one cycle of ack to the granted master and no ack to the other.
REQ-023 SHALL, for reads, load m_dat_i into that master's hold register in RESP_*, with the master's dat_o showing m_dat_i combinationally during RESP and the held value thereafter.
REQ-024 SHALL leave dat_o unchanged on writes.
REQ-025 SHALL, in RESP_*, arbitrate for the next grant excluding the master being acked this cycle, going directly to the other ISSUE_* if that master requests, else to IDLE; the earliest back-to-back cadence is one transfer per two cycles.
REQ-026 SHALL give a latency of 2 cycles with zero memory wait (stb sampled in IDLE, ISSUE, then RESP with ack), plus one cycle per m_ack_i=0 cycle.
REQ-027 SHALL complete and ack a granted transfer whose master drops stb mid-transfer (protocol violation); no abort.
REQ-028 SHALL never assert i_ack_o and d_ack_o in the same cycle, and never assert m_stb_o outside ISSUE_*.

Reset
REQ-029 SHALL, with rst_n=0 at a rising edge, enter IDLE and set m_stb_o=0, m_we_o=0, m_adr_o=0, m_dat_o=0, i_ack_o=0, d_ack_o=0, i_dat_o=0, d_dat_o=0, and last-grant=i.
REQ-030 SHALL abandon an in-flight transfer when reset occurs mid-transfer, with no ack issued after reset.

Structure
REQ-031 SHALL place the FSM state encoding and the grant encoding (GNT_I, GNT_D) in shared package mem_arb_pkg.
REQ-032 SHALL implement the two-way tie-break in sub-module mem_arb_pick (inputs: two requests, mask, last-grant, D_PRIORITY; output: grant).

Verification
REQ-033 SHALL verify: single read i_adr_i=0x0000_0010 with memory word 0x2402_0005 -> i_ack_o high exactly at cycle 2 and i_dat_o=0x2402_0005.
REQ-034 SHALL verify: simultaneous i read 0x0 and d write 0x100 of 0xDEAD_BEEF with D_PRIORITY=1 -> d_ack_o at cycle 2 and i_ack_o at cycle 4; a subsequent read of 0x100 returns 0xDEAD_BEEF.
REQ-035 SHALL verify: D_PRIORITY=0 with both stb held high for 8 transfers -> acks alternate d,i,d,i and no port waits more than one transfer.
REQ-036 SHALL verify: m_ack_i held 0 for 3 cycles in ISSUE_D -> m_adr_o and m_dat_o stable throughout, and d_ack_o arrives at cycle 5.
REQ-037 SHALL verify: rst_n=0 asserted in ISSUE_I -> all outputs 0 on the next cycle, state is IDLE, and no i_ack_o follows.
REQ-038 SHALL verify: d_stb_i dropped in ISSUE_D -> the write still lands and d_ack_o pulses once.
